// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned DEF_REG_ADDR_W = 4;
   localparam int unsigned DEF_NUM_STAGES = 3;
   localparam int unsigned FWD_REGFILE    = 0;

   typedef logic [$clog2(DEF_NUM_STAGES)-1:0] fwd_sel_t;

   typedef struct packed {
      logic                      valid;
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic                      reg_write;
      logic                      mem_to_reg;
   } hazard_entry_t;

   typedef struct packed {
      logic                      halt;
      logic [DEF_REG_ADDR_W-1:0] deco_a1;
      logic [DEF_REG_ADDR_W-1:0] deco_a2;
      logic                      deco_a1_used;
      logic                      deco_a2_used;
      logic [DEF_REG_ADDR_W-1:0] deco_rd;
      logic                      deco_reg_write;
      logic                      deco_mem_to_reg;
      logic                      pc_src_exe;
   } hazard_ctrl_in_t;

   typedef struct packed {
      logic     stall_fetch;
      logic     stall_deco;
      logic     flush_deco;
      logic     flush_exe;
      fwd_sel_t fwd_a_sel;
      fwd_sel_t fwd_b_sel;
   } hazard_ctrl_out_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Priority match of one EX operand against the MEM..WB scoreboard entries;
// the youngest qualifying producer wins.
module pipe_hazard_ctrl_fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W     = 4,
   parameter int unsigned NUM_STAGES     = 3,
   parameter int unsigned LOAD_FWD_STAGE = 2,
   parameter int unsigned PC_REG         = 15,
   parameter int unsigned SEL_W          = $clog2(NUM_STAGES)
) (
   input  logic [NUM_STAGES-1:1]              ent_valid,
   input  logic [NUM_STAGES-1:1]              ent_reg_write,
   input  logic [NUM_STAGES-1:1]              ent_mem_to_reg,
   input  logic [(NUM_STAGES-1)*REG_ADDR_W-1:0] ent_rd,
   input  logic [REG_ADDR_W-1:0]              src,
   input  logic                               src_used,
   output logic [SEL_W-1:0]                   sel
);

   localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

   logic found;

   always_comb begin
      sel   = SEL_W'(FWD_REGFILE);
      found = 1'b0;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
         if (!found && ent_valid[k] && ent_reg_write[k] && src_used && (src != PC_ADDR) &&
             (ent_rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == src) &&
             (!ent_mem_to_reg[k] || (k >= LOAD_FWD_STAGE))) begin
            sel   = SEL_W'(k);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: scoreboard of in-flight destinations,
// forwarding selects, load-use stall, branch flush, halt freeze, event counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W     = 4,
   parameter int unsigned NUM_STAGES     = 3,
   parameter int unsigned LOAD_FWD_STAGE = 2,
   parameter int unsigned PC_REG         = 15,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned SEL_W          = $clog2(NUM_STAGES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  halt,
   input  logic [REG_ADDR_W-1:0] deco_a1,
   input  logic [REG_ADDR_W-1:0] deco_a2,
   input  logic                  deco_a1_used,
   input  logic                  deco_a2_used,
   input  logic [REG_ADDR_W-1:0] deco_rd,
   input  logic                  deco_reg_write,
   input  logic                  deco_mem_to_reg,
   input  logic                  pc_src_exe,
   output logic                  stall_fetch,
   output logic                  stall_deco,
   output logic                  flush_deco,
   output logic                  flush_exe,
   output logic [SEL_W-1:0]      fwd_a_sel,
   output logic [SEL_W-1:0]      fwd_b_sel,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

   logic [NUM_STAGES-1:0]                 vld_q, vld_d;
   logic [NUM_STAGES-1:0]                 rw_q, rw_d;
   logic [NUM_STAGES-1:0]                 m2r_q, m2r_d;
   logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
   logic [REG_ADDR_W-1:0]                 ex_a1_q, ex_a1_d, ex_a2_q, ex_a2_d;
   logic                                  ex_a1_used_q, ex_a1_used_d;
   logic                                  ex_a2_used_q, ex_a2_used_d;
   logic [CNT_W-1:0]                      stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]                      flush_cnt_q, flush_cnt_d;

   logic                                  luse;
   logic                                  bubble;
   logic [SEL_W-1:0]                      fwd_a_raw, fwd_b_raw;

   pipe_hazard_ctrl_fwd_select #(
      .REG_ADDR_W    (REG_ADDR_W),
      .NUM_STAGES    (NUM_STAGES),
      .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
      .PC_REG        (PC_REG),
      .SEL_W         (SEL_W)
   ) u_fwd_a (
      .ent_valid     (vld_q[NUM_STAGES-1:1]),
      .ent_reg_write (rw_q[NUM_STAGES-1:1]),
      .ent_mem_to_reg(m2r_q[NUM_STAGES-1:1]),
      .ent_rd        (rd_q[NUM_STAGES-1:1]),
      .src           (ex_a1_q),
      .src_used      (ex_a1_used_q),
      .sel           (fwd_a_raw)
   );

   pipe_hazard_ctrl_fwd_select #(
      .REG_ADDR_W    (REG_ADDR_W),
      .NUM_STAGES    (NUM_STAGES),
      .LOAD_FWD_STAGE(LOAD_FWD_STAGE),
      .PC_REG        (PC_REG),
      .SEL_W         (SEL_W)
   ) u_fwd_b (
      .ent_valid     (vld_q[NUM_STAGES-1:1]),
      .ent_reg_write (rw_q[NUM_STAGES-1:1]),
      .ent_mem_to_reg(m2r_q[NUM_STAGES-1:1]),
      .ent_rd        (rd_q[NUM_STAGES-1:1]),
      .src           (ex_a2_q),
      .src_used      (ex_a2_used_q),
      .sel           (fwd_b_raw)
   );

   // A load still too young to forward blocks a decode instruction reading its rd.
   always_comb begin
      luse = 1'b0;
      for (int unsigned j = 0; j < NUM_STAGES; j++) begin
         if ((j + 1 < LOAD_FWD_STAGE) && vld_q[j] && m2r_q[j] && rw_q[j] &&
             ((deco_a1_used && (deco_a1 == rd_q[j]) && (deco_a1 != PC_ADDR)) ||
              (deco_a2_used && (deco_a2 == rd_q[j]) && (deco_a2 != PC_ADDR))))
            luse = 1'b1;
      end
   end

   always_comb begin
      stall_fetch = 1'b0;
      stall_deco  = 1'b0;
      flush_deco  = 1'b0;
      flush_exe   = 1'b0;
      fwd_a_sel   = fwd_a_raw;
      fwd_b_sel   = fwd_b_raw;
      if (!reset) begin
         flush_deco = 1'b1;
         flush_exe  = 1'b1;
         fwd_a_sel  = SEL_W'(FWD_REGFILE);
         fwd_b_sel  = SEL_W'(FWD_REGFILE);
      end else if (halt) begin
         stall_fetch = 1'b1;
         stall_deco  = 1'b1;
      end else if (pc_src_exe) begin
         flush_deco = 1'b1;
         flush_exe  = 1'b1;
      end else if (luse) begin
         stall_fetch = 1'b1;
         stall_deco  = 1'b1;
         flush_exe   = 1'b1;
      end
   end

   assign bubble = pc_src_exe | luse;

   always_comb begin
      vld_d        = vld_q;
      rw_d         = rw_q;
      m2r_d        = m2r_q;
      rd_d         = rd_q;
      ex_a1_d      = ex_a1_q;
      ex_a2_d      = ex_a2_q;
      ex_a1_used_d = ex_a1_used_q;
      ex_a2_used_d = ex_a2_used_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (!halt) begin
         for (int unsigned k = 1; k < NUM_STAGES; k++) begin
            vld_d[k] = vld_q[k-1];
            rw_d[k]  = rw_q[k-1];
            m2r_d[k] = m2r_q[k-1];
            rd_d[k]  = rd_q[k-1];
         end
         vld_d[0]     = ~bubble;
         rw_d[0]      = bubble ? 1'b0 : deco_reg_write;
         m2r_d[0]     = bubble ? 1'b0 : deco_mem_to_reg;
         rd_d[0]      = bubble ? '0 : deco_rd;
         ex_a1_d      = bubble ? '0 : deco_a1;
         ex_a2_d      = bubble ? '0 : deco_a2;
         ex_a1_used_d = bubble ? 1'b0 : deco_a1_used;
         ex_a2_used_d = bubble ? 1'b0 : deco_a2_used;
         if (luse && !pc_src_exe && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (pc_src_exe && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q        <= '0;
         rw_q         <= '0;
         m2r_q        <= '0;
         rd_q         <= '0;
         ex_a1_q      <= '0;
         ex_a2_q      <= '0;
         ex_a1_used_q <= 1'b0;
         ex_a2_used_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         vld_q        <= vld_d;
         rw_q         <= rw_d;
         m2r_q        <= m2r_d;
         rd_q         <= rd_d;
         ex_a1_q      <= ex_a1_d;
         ex_a2_q      <= ex_a2_d;
         ex_a1_used_q <= ex_a1_used_d;
         ex_a2_used_q <= ex_a2_used_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised plus directed bench for pipe_hazard_ctrl against an in-bench
// behavioural model of the pipeline's in-flight instructions.
module tb_pipe_hazard_ctrl;

   localparam int NS   = 3;
   localparam int LFS  = 2;
   localparam int PC   = 15;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       reset, halt, pc_src_exe;
   logic [3:0] deco_a1, deco_a2, deco_rd;
   logic       deco_a1_used, deco_a2_used, deco_reg_write, deco_mem_to_reg;
   logic       stall_fetch, stall_deco, flush_deco, flush_exe;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [CW-1:0] stall_cnt, flush_cnt;

   pipe_hazard_ctrl #(
      .REG_ADDR_W(4), .NUM_STAGES(NS), .LOAD_FWD_STAGE(LFS), .PC_REG(PC), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .halt(halt),
      .deco_a1(deco_a1), .deco_a2(deco_a2),
      .deco_a1_used(deco_a1_used), .deco_a2_used(deco_a2_used),
      .deco_rd(deco_rd), .deco_reg_write(deco_reg_write), .deco_mem_to_reg(deco_mem_to_reg),
      .pc_src_exe(pc_src_exe),
      .stall_fetch(stall_fetch), .stall_deco(stall_deco),
      .flush_deco(flush_deco), .flush_exe(flush_exe),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   // In-flight instruction record; index 0 = EX, index NS-1 = WB.
   typedef struct { bit v; int rd; bit rw; bit ld; int a1; int a2; bit u1; bit u2; } instr_t;
   instr_t pipe[NS];
   int m_sc, m_fc;
   int e_sf, e_sd, e_fd, e_fe, e_fa, e_fb, e_luse;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   function automatic int producer(input int src, input bit used);
      if (!used || src == PC) return 0;
      for (int k = 1; k < NS; k++)
         if (pipe[k].v && pipe[k].rw && pipe[k].rd == src && (!pipe[k].ld || k >= LFS))
            return k;
      return 0;
   endfunction

   task automatic model_expect();
      e_luse = 0;
      for (int j = 0; j < LFS - 1; j++)
         if (pipe[j].v && pipe[j].ld && pipe[j].rw &&
             ((deco_a1_used && int'(deco_a1) == pipe[j].rd && deco_a1 != 4'(PC)) ||
              (deco_a2_used && int'(deco_a2) == pipe[j].rd && deco_a2 != 4'(PC))))
            e_luse = 1;
      e_fa = producer(pipe[0].a1, pipe[0].u1);
      e_fb = producer(pipe[0].a2, pipe[0].u2);
      e_sf = 0; e_fd = 0; e_fe = 0;
      if (!reset) begin
         e_fd = 1; e_fe = 1; e_fa = 0; e_fb = 0;
      end else if (halt) begin
         e_sf = 1;
      end else if (pc_src_exe) begin
         e_fd = 1; e_fe = 1;
      end else if (e_luse != 0) begin
         e_sf = 1; e_fe = 1;
      end
      e_sd = e_sf;
   endtask

   task automatic model_clock();
      instr_t nw;
      if (!reset) begin
         foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0, 0, 0, 0, 0};
         m_sc = 0; m_fc = 0;
      end else if (!halt) begin
         for (int k = NS - 1; k > 0; k--) pipe[k] = pipe[k-1];
         if (e_fe != 0) nw = '{0, 0, 0, 0, 0, 0, 0, 0};
         else nw = '{1, int'(deco_rd), deco_reg_write, deco_mem_to_reg,
                     int'(deco_a1), int'(deco_a2), deco_a1_used, deco_a2_used};
         pipe[0] = nw;
         if (e_luse != 0 && !pc_src_exe && m_sc < CMAX) m_sc++;
         if (pc_src_exe && m_fc < CMAX) m_fc++;
      end
   endtask

   // Apply inputs away from the active edge, then compare every output with the model.
   task automatic drive(input int a1, input bit u1, input int a2, input bit u2,
                        input int rd, input bit rw, input bit ld,
                        input bit pc, input bit hl, input bit rst);
      @(negedge clk);
      deco_a1 = 4'(a1); deco_a1_used = u1; deco_a2 = 4'(a2); deco_a2_used = u2;
      deco_rd = 4'(rd); deco_reg_write = rw; deco_mem_to_reg = ld;
      pc_src_exe = pc; halt = hl; reset = rst;
      #1;
      model_expect();
      chk("stall_fetch", int'(stall_fetch), e_sf);
      chk("stall_deco",  int'(stall_deco),  e_sd);
      chk("flush_deco",  int'(flush_deco),  e_fd);
      chk("flush_exe",   int'(flush_exe),   e_fe);
      chk("fwd_a_sel",   int'(fwd_a_sel),   e_fa);
      chk("fwd_b_sel",   int'(fwd_b_sel),   e_fb);
      chk("stall_cnt",   int'(stall_cnt),   m_sc);
      chk("flush_cnt",   int'(flush_cnt),   m_fc);
   endtask

   task automatic adv();
      @(posedge clk);
      model_clock();
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      adv();
   endtask

   task automatic insn(input int a1, input bit u1, input int a2, input bit u2,
                       input int rd, input bit rw, input bit ld);
      drive(a1, u1, a2, u2, rd, rw, ld, 0, 0, 1);
      adv();
   endtask

   function automatic int rreg();
      int r;
      r = int'($urandom_range(0, 4));
      return (r == 4) ? PC : r + 1;
   endfunction

   initial begin
      foreach (pipe[k]) pipe[k] = '{0, 0, 0, 0, 0, 0, 0, 0};
      m_sc = 0; m_fc = 0;
      reset = 1'b0; halt = 1'b0; pc_src_exe = 1'b0;
      deco_a1 = '0; deco_a2 = '0; deco_rd = '0;
      deco_a1_used = 1'b0; deco_a2_used = 1'b0;
      deco_reg_write = 1'b0; deco_mem_to_reg = 1'b0;
      @(posedge clk);

      // reset held low with random decode/control inputs
      for (int i = 0; i < 2; i++) begin
         drive(rreg(), 1, rreg(), 1, rreg(), 1, 1, 1, 1, 0);
         chk("rst_stall_fetch", int'(stall_fetch), 0);
         chk("rst_flush_deco",  int'(flush_deco),  1);
         chk("rst_flush_exe",   int'(flush_exe),   1);
         chk("rst_fwd_a",       int'(fwd_a_sel),   0);
         adv();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("post_rst_flush_deco", int'(flush_deco), 0);
      chk("post_rst_flush_exe",  int'(flush_exe),  0);
      chk("post_rst_stall_cnt",  int'(stall_cnt),  0);
      adv();

      // LDR R4 ; ADD R5,R4,R6 -> one stall cycle then load forwarded from WB
      insn(0, 0, 0, 0, 4, 1, 1);
      drive(4, 1, 6, 1, 5, 1, 0, 0, 0, 1);
      chk("luse_stall_fetch", int'(stall_fetch), 1);
      chk("luse_stall_deco",  int'(stall_deco),  1);
      chk("luse_flush_exe",   int'(flush_exe),   1);
      adv();
      drive(4, 1, 6, 1, 5, 1, 0, 0, 0, 1);
      chk("luse_released", int'(stall_fetch), 0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("luse_fwd_a", int'(fwd_a_sel), 2);
      chk("luse_cnt",   int'(stall_cnt), 1);
      adv();
      repeat (3) nop();

      // ADD R1 ; ADD R2,R1,R3 -> forward from MEM
      insn(0, 0, 0, 0, 1, 1, 0);
      insn(1, 1, 3, 1, 2, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("fwd_mem", int'(fwd_a_sel), 1);
      adv();
      repeat (3) nop();

      // one NOP gap -> forward from WB
      insn(0, 0, 0, 0, 1, 1, 0);
      nop();
      insn(1, 1, 3, 1, 2, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("fwd_wb", int'(fwd_a_sel), 2);
      adv();
      repeat (3) nop();

      // R1 in both MEM and WB -> youngest (MEM) wins on operand b
      insn(0, 0, 0, 0, 1, 1, 0);
      insn(0, 0, 0, 0, 1, 1, 0);
      insn(3, 1, 1, 1, 2, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("fwd_youngest_b", int'(fwd_b_sel), 1);
      adv();
      repeat (3) nop();

      // PC register is never forwarded
      insn(0, 0, 0, 0, 15, 1, 0);
      insn(15, 1, 0, 0, 2, 1, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("fwd_pc_reg", int'(fwd_a_sel), 0);
      adv();
      repeat (3) nop();

      // branch in the same cycle as a load-use match
      insn(0, 0, 0, 0, 4, 1, 1);
      drive(4, 1, 0, 0, 5, 1, 0, 1, 0, 1);
      chk("br_flush_deco", int'(flush_deco),  1);
      chk("br_flush_exe",  int'(flush_exe),   1);
      chk("br_no_stall",   int'(stall_fetch), 0);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("br_flush_cnt", int'(flush_cnt), 1);
      chk("br_stall_cnt", int'(stall_cnt), 1);
      adv();
      repeat (3) nop();

      // halt for 3 cycles in the middle of a load-use stall
      insn(0, 0, 0, 0, 7, 1, 1);
      for (int i = 0; i < 3; i++) begin
         drive(7, 1, 0, 0, 5, 1, 0, 0, 1, 1);
         chk("halt_stall",     int'(stall_fetch), 1);
         chk("halt_no_flush",  int'(flush_exe),   0);
         chk("halt_cnt_frozen", int'(stall_cnt),  1);
         adv();
      end
      drive(7, 1, 0, 0, 5, 1, 0, 0, 0, 1);
      chk("halt_resume_stall", int'(stall_deco), 1);
      chk("halt_resume_flush", int'(flush_exe),  1);
      adv();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("halt_resume_cnt", int'(stall_cnt), 2);
      adv();
      repeat (3) nop();

      // drive the stall counter into saturation
      repeat (16) begin
         insn(0, 0, 0, 0, 4, 1, 1);
         insn(4, 1, 0, 0, 5, 1, 0);
         insn(4, 1, 0, 0, 5, 1, 0);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("stall_cnt_sat", int'(stall_cnt), CMAX);
      adv();

      // randomised traffic over a small register set
      repeat (4000) begin
         drive(rreg(), 1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)),
               rreg(), ($urandom_range(0, 99) < 80), ($urandom_range(0, 99) < 35),
               ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 8),
               !($urandom_range(0, 99) < 3));
         adv();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
